seg7_frame_arbiter: RTL and testbench

Shares the 8-character seven-segment display between two requesters and drives the 64-bit `asciix8` bus of `seg7x8`. The high-priority source (alerts, status messages) preempts the low-priority source (live pitch/note readout), and each high-priority frame stays on screen for a guaranteed dwell time. The display then reverts to the most recent low-priority frame. The block sits between the application logic and `seg7x8` and replaces ad-hoc writes to the display register.

---
 rtl/seg7_pkg.sv | 12 +
 rtl/seg7_dwell_timer.sv | 27 ++
 rtl/seg7_frame_arbiter.sv | 94 +++++++++
 tb/tb_seg7_frame_arbiter.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment display path: frame width, blank frame
// and arbiter state encoding.
package seg7_pkg;

   localparam int unsigned SEG7_FRAME_W = 64;

   localparam logic [SEG7_FRAME_W-1:0] SEG7_BLANK = '0;

   localparam logic [0:0] ST_LOW  = 1'b0;
   localparam logic [0:0] ST_HOLD = 1'b1;

endpackage

// File: rtl/seg7_dwell_timer.sv
// Loadable down-counter that saturates at zero; times the high-priority dwell.
module seg7_dwell_timer #(
   parameter int unsigned CNT_W = 2
) (
   input  logic             CLK100MHZ,
   input  logic             resetn,
   input  logic             clear,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   output logic             zero
);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge CLK100MHZ) begin
      if (!resetn || clear) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (cnt != '0) begin
         cnt <= cnt - CNT_W'(1);
      end
   end

   assign zero = (cnt == '0);

endmodule

// File: rtl/seg7_frame_arbiter.sv
// Two-source arbiter for the 8-character display: high-priority frames preempt
// and dwell for DWELL_CYCLES, then the latest low-priority frame is restored.
module seg7_frame_arbiter
   import seg7_pkg::*;
#(
   parameter int unsigned DWELL_CYCLES = 100_000_000,
   parameter int unsigned CNT_W        = $clog2(DWELL_CYCLES)
) (
   input  logic                    CLK100MHZ,
   input  logic                    resetn,
   input  logic                    clear,
   input  logic                    hi_valid,
   input  logic [SEG7_FRAME_W-1:0] hi_frame,
   output logic                    hi_ready,
   input  logic                    lo_valid,
   input  logic [SEG7_FRAME_W-1:0] lo_frame,
   output logic                    lo_ready,
   output logic [SEG7_FRAME_W-1:0] asciix8,
   output logic                    owner
);

   logic [0:0]              state_q;
   logic [0:0]              state_d;
   logic [SEG7_FRAME_W-1:0] shadow;
   logic                    hi_xfer;
   logic                    lo_xfer;
   logic                    zero;

   seg7_dwell_timer #(
      .CNT_W (CNT_W)
   ) u_timer (
      .CLK100MHZ (CLK100MHZ),
      .resetn    (resetn),
      .clear     (clear),
      .load      (hi_xfer),
      .load_val  (CNT_W'(DWELL_CYCLES - 1)),
      .zero      (zero)
   );

   // Ready depends only on state, timer, clear and reset -- never on valid.
   always_comb begin
      state_d  = state_q;
      hi_ready = 1'b0;
      lo_ready = 1'b0;
      if (resetn && !clear) begin
         lo_ready = 1'b1;
         hi_ready = (state_q == ST_LOW) || zero;
      end
      hi_xfer = hi_valid & hi_ready;
      lo_xfer = lo_valid & lo_ready;
      if (clear) begin
         state_d = ST_LOW;
      end else begin
         case (state_q)
            ST_LOW:  if (hi_xfer) state_d = ST_HOLD;
            ST_HOLD: if (zero && !hi_xfer) state_d = ST_LOW;
            default: state_d = ST_LOW;
         endcase
      end
   end

   always_ff @(posedge CLK100MHZ) begin
      if (!resetn) begin
         state_q <= ST_LOW;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge CLK100MHZ) begin
      if (!resetn || clear) begin
         asciix8 <= SEG7_BLANK;
         shadow  <= SEG7_BLANK;
         owner   <= 1'b0;
      end else begin
         if (lo_xfer) begin
            shadow <= lo_frame;
         end
         if (hi_xfer) begin
            asciix8 <= hi_frame;
            owner   <= 1'b1;
         end else if (state_q == ST_LOW) begin
            if (lo_xfer) begin
               asciix8 <= lo_frame;
            end
         end else if (zero) begin
            // Dwell expired: bypass a frame arriving this cycle, else restore shadow.
            asciix8 <= lo_valid ? lo_frame : shadow;
            owner   <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_seg7_frame_arbiter.sv
// Directed bench for seg7_frame_arbiter with a 4-cycle dwell.
module tb_seg7_frame_arbiter;

   logic        CLK100MHZ;
   logic        resetn;
   logic        clear;
   logic        hi_valid;
   logic [63:0] hi_frame;
   logic        hi_ready;
   logic        lo_valid;
   logic [63:0] lo_frame;
   logic        lo_ready;
   logic [63:0] asciix8;
   logic        owner;

   int n_cmp = 0;
   int n_err = 0;

   logic [63:0] f_a4 = "NOTE A4 ";
   logic [63:0] f_b5 = "NOTE B5 ";
   logic [63:0] f_c3 = "NOTE C3 ";
   logic [63:0] f_d2 = "NOTE D2 ";
   logic [63:0] f_h  = "ALERT!! ";
   logic [63:0] f_h1 = "STATUS 1";
   logic [63:0] f_h2 = "STATUS 2";

   seg7_frame_arbiter #(
      .DWELL_CYCLES (4)
   ) dut (
      .CLK100MHZ (CLK100MHZ),
      .resetn    (resetn),
      .clear     (clear),
      .hi_valid  (hi_valid),
      .hi_frame  (hi_frame),
      .hi_ready  (hi_ready),
      .lo_valid  (lo_valid),
      .lo_frame  (lo_frame),
      .lo_ready  (lo_ready),
      .asciix8   (asciix8),
      .owner     (owner)
   );

   initial CLK100MHZ = 1'b0;
   always #5 CLK100MHZ = ~CLK100MHZ;

   task automatic step();
      @(posedge CLK100MHZ);
      #1;
   endtask

   task automatic test_reset();
      resetn   = 1'b0;
      clear    = 1'b0;
      hi_valid = 1'b1;
      hi_frame = f_h;
      lo_valid = 1'b1;
      lo_frame = f_a4;
      for (int i = 0; i < 3; i++) begin
         step();
         n_cmp++;
         if (asciix8 !== 64'h0) begin
            n_err++; $display("FAIL reset_ascii cyc%0d got %h want 0", i, asciix8);
         end
         n_cmp++;
         if (owner !== 1'b0) begin
            n_err++; $display("FAIL reset_owner cyc%0d got %b want 0", i, owner);
         end
         n_cmp++;
         if ({hi_ready, lo_ready} !== 2'b00) begin
            n_err++; $display("FAIL reset_ready cyc%0d got %b want 00", i, {hi_ready, lo_ready});
         end
      end
      hi_valid = 1'b0;
      lo_valid = 1'b0;
      resetn   = 1'b1;
      #1;
      n_cmp++;
      if ({hi_ready, lo_ready} !== 2'b11) begin
         n_err++; $display("FAIL post_reset_ready got %b want 11", {hi_ready, lo_ready});
      end
   endtask

   task automatic test_lo_only();
      lo_frame = f_a4;
      lo_valid = 1'b1;
      step();
      lo_valid = 1'b0;
      n_cmp++;
      if (asciix8 !== f_a4) begin
         n_err++; $display("FAIL lo_first got %h want %h", asciix8, f_a4);
      end
      lo_frame = f_b5;
      lo_valid = 1'b1;
      step();
      lo_valid = 1'b0;
      n_cmp++;
      if (asciix8 !== f_b5) begin
         n_err++; $display("FAIL lo_second got %h want %h", asciix8, f_b5);
      end
      n_cmp++;
      if (owner !== 1'b0) begin
         n_err++; $display("FAIL lo_owner got %b want 0", owner);
      end
   endtask

   task automatic test_preempt();
      hi_frame = f_h;
      hi_valid = 1'b1;
      step();
      hi_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         n_cmp++;
         if (asciix8 !== f_h || owner !== 1'b1) begin
            n_err++; $display("FAIL preempt_hold cyc%0d got %h/%b want %h/1", i, asciix8, owner, f_h);
         end
         n_cmp++;
         if (hi_ready !== (i == 3)) begin
            n_err++; $display("FAIL preempt_hi_ready cyc%0d got %b want %b", i, hi_ready, i == 3);
         end
         n_cmp++;
         if (lo_ready !== 1'b1) begin
            n_err++; $display("FAIL preempt_lo_ready cyc%0d got %b want 1", i, lo_ready);
         end
         if (i == 0) begin
            lo_frame = f_c3;
            lo_valid = 1'b1;
         end
         step();
         lo_valid = 1'b0;
      end
      n_cmp++;
      if (asciix8 !== f_c3 || owner !== 1'b0) begin
         n_err++; $display("FAIL preempt_revert got %h/%b want %h/0", asciix8, owner, f_c3);
      end
   endtask

   task automatic test_back_to_back();
      hi_frame = f_h1;
      hi_valid = 1'b1;
      step();
      hi_frame = f_h2;
      for (int i = 0; i < 4; i++) begin
         n_cmp++;
         if (asciix8 !== f_h1) begin
            n_err++; $display("FAIL b2b_h1 cyc%0d got %h want %h", i, asciix8, f_h1);
         end
         n_cmp++;
         if (hi_ready !== (i == 3)) begin
            n_err++; $display("FAIL b2b_ready cyc%0d got %b want %b", i, hi_ready, i == 3);
         end
         step();
      end
      hi_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         n_cmp++;
         if (asciix8 !== f_h2 || owner !== 1'b1) begin
            n_err++; $display("FAIL b2b_h2 cyc%0d got %h/%b want %h/1", i, asciix8, owner, f_h2);
         end
         step();
      end
      n_cmp++;
      if (asciix8 !== f_c3 || owner !== 1'b0) begin
         n_err++; $display("FAIL b2b_revert got %h/%b want %h/0", asciix8, owner, f_c3);
      end
   endtask

   task automatic test_simultaneous();
      hi_frame = f_h;
      hi_valid = 1'b1;
      lo_frame = f_d2;
      lo_valid = 1'b1;
      step();
      hi_valid = 1'b0;
      lo_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         n_cmp++;
         if (asciix8 !== f_h || owner !== 1'b1) begin
            n_err++; $display("FAIL simul_hold cyc%0d got %h/%b want %h/1", i, asciix8, owner, f_h);
         end
         step();
      end
      n_cmp++;
      if (asciix8 !== f_d2 || owner !== 1'b0) begin
         n_err++; $display("FAIL simul_shadow got %h/%b want %h/0", asciix8, owner, f_d2);
      end
   endtask

   task automatic test_clear();
      hi_frame = f_h;
      hi_valid = 1'b1;
      step();
      hi_valid = 1'b0;
      step();
      clear = 1'b1;
      #1;
      n_cmp++;
      if ({hi_ready, lo_ready} !== 2'b00) begin
         n_err++; $display("FAIL clear_ready got %b want 00", {hi_ready, lo_ready});
      end
      step();
      clear = 1'b0;
      #1;
      n_cmp++;
      if (asciix8 !== 64'h0 || owner !== 1'b0) begin
         n_err++; $display("FAIL clear_blank got %h/%b want 0/0", asciix8, owner);
      end
      n_cmp++;
      if (hi_ready !== 1'b1) begin
         n_err++; $display("FAIL clear_low_state hi_ready got %b want 1", hi_ready);
      end
      for (int i = 0; i < 5; i++) begin
         step();
         n_cmp++;
         if (asciix8 !== 64'h0 || owner !== 1'b0) begin
            n_err++; $display("FAIL clear_stale cyc%0d got %h/%b want 0/0", i, asciix8, owner);
         end
      end
      lo_frame = f_a4;
      lo_valid = 1'b1;
      step();
      lo_valid = 1'b0;
      n_cmp++;
      if (asciix8 !== f_a4 || owner !== 1'b0) begin
         n_err++; $display("FAIL clear_then_lo got %h/%b want %h/0", asciix8, owner, f_a4);
      end
   endtask

   initial begin
      test_reset();
      test_lo_only();
      test_preempt();
      test_back_to_back();
      test_simultaneous();
      test_clear();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
